pll_lock_supervisor: RTL



---
 rtl/pll_sup_pkg.sv | 27 ++
 rtl/sync_bit.sv | 35 +++
 rtl/pll_lock_supervisor.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
//============================================================
// pll_sup_pkg: shared state encoding for the PLL lock supervisor
// Rev 1.0
//============================================================
`default_nettype none

package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int STATE_W = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_bit.sv
//============================================================
// sync_bit: STAGES-deep single-bit synchroniser, async active-low reset
// Rev 1.0
//============================================================
`default_nettype none

module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
//============================================================
// pll_lock_supervisor: drives PLL RESETB/BYPASS, qualifies LOCK into ready/fault
// Rev 1.0
//============================================================
`default_nettype none

module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic                               clock_in,
  input  logic                               resetn,
  input  logic                               pll_locked,
  input  logic                               restart,
  output logic                               pll_resetb,
  output logic                               pll_bypass,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [CNT_W-1:0]                   loss_count,
  output logic [STATE_W-1:0]                 state
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  // +1 so the timer can hold the largest terminal value even when it is a power of two
  localparam int TW = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  logic lock_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clock_in),
    .rst_n (resetn),
    .d     (pll_locked),
    .q     (lock_s)
  );

  pll_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             pll_resetb_q, pll_bypass_q, ready_q, fault_q;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      ST_RST_PLL: begin
        if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (timer_q == LOCK_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_RST_PLL;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (timer_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
          state_d = ST_RST_PLL;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RST_PLL;
      end
    endcase

    // Restart overrides the transition but not the loss already counted above
    if (restart) begin
      state_d = ST_RST_PLL;
      retry_d = '0;
    end

    if (restart || (state_d != state_q)) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_RST_PLL;
      timer_q      <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_resetb_q <= 1'b0;
      pll_bypass_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= (state_d != ST_RST_PLL);
      pll_bypass_q <= (state_d == ST_FAULT);
      ready_q      <= (state_d == ST_RUN);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign pll_bypass  = pll_bypass_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;
  assign state       = state_q;

endmodule

`default_nettype wire
